// File: rtl/uno_sched_pkg.sv
// Shared types for the Uno turn scheduler: seat index, turn actions, FSM states.
// Latency: n/a (types, constants and pure combinational helpers only).
// Backpressure: n/a.
package uno_sched_pkg;

    typedef logic [1:0] seat_t;

    typedef enum logic [2:0] {
        ACT_NORMAL  = 3'd0,
        ACT_SKIP    = 3'd1,
        ACT_REVERSE = 3'd2,
        ACT_DRAW2   = 3'd3,
        ACT_WILD4   = 3'd4,
        ACT_PASS    = 3'd5
    } action_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PACE    = 3'd1,
        ST_ACTIVE  = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_PENALTY = 3'd4,
        ST_END     = 3'd5
    } sched_state_e;

    localparam seat_t HUMAN_SEAT = 2'd0;

    // Move n seats around the table; dir=1 walks downwards. Wraps mod 4.
    function automatic seat_t seat_step(input seat_t s, input logic dir, input logic [1:0] n);
        seat_t r;
        if (dir)
            r = seat_t'(s - n);
        else
            r = seat_t'(s + n);
        return r;
    endfunction

    function automatic logic [3:0] seat_onehot(input seat_t s);
        logic [3:0] one;
        one = 4'b0001;
        return one << s;
    endfunction

endpackage

// File: rtl/uno_pace_timer.sv
// Pacing delay for computer seats: loadable down-counter with a terminal pulse.
// Latency: o_expire rises LOAD_VAL+1 enabled cycles after i_load.
// Backpressure: none; counting pauses while i_en is low.
module uno_pace_timer #(
    parameter int             CW       = 20,
    parameter logic [CW-1:0]  LOAD_VAL = '0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    logic [CW-1:0] cnt;

    // Load on entry to the pacing window, then count down to zero and park there.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            cnt <= '0;
        else if (i_load)
            cnt <= LOAD_VAL;
        else if (i_en && (cnt != '0))
            cnt <= cnt - CW'(1);
    end

    // Terminal count; the owner leaves the enabled state on this pulse so it lasts one cycle.
    assign o_expire = i_en && !i_load && (cnt == '0);

endmodule

// File: rtl/uno_turn_scheduler.sv
// Turn sequencer/arbiter for four Uno seats: grants one seat, applies skip/reverse/draw effects.
// Latency: i_done sample -> o_turn next edge after ADVANCE; o_go on ACTIVE entry, COM_DELAY edges later for computer seats.
// Backpressure: no valid/ready; penalty request is held until i_penalty_ack, stray pulses are ignored.
module uno_turn_scheduler
    import uno_sched_pkg::*;
#(
    parameter int COM_DELAY = 500000,
    parameter int CW        = 20
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_done,
    input  logic [2:0] i_action,
    input  logic       i_hand_empty,
    input  logic       i_penalty_ack,
    output logic [1:0] o_turn,
    output logic [3:0] o_grant,
    output logic       o_go,
    output logic       o_dir,
    output logic       o_penalty_req,
    output logic [1:0] o_penalty_target,
    output logic [2:0] o_penalty_cnt,
    output logic       o_end,
    output logic [1:0] o_winner
);

    localparam logic [CW-1:0] PACE_LOAD = CW'(COM_DELAY - 1);

    sched_state_e state;
    seat_t        turn;
    logic         dir;
    action_e      act_q;
    logic [3:0]   grant;
    logic         go;
    logic         pen_req;
    seat_t        pen_tgt;
    logic [2:0]   pen_cnt;
    logic         end_q;
    seat_t        winner;

    seat_t        adv_turn;
    logic         adv_dir;
    logic         adv_pen;
    seat_t        adv_tgt;
    logic [2:0]   adv_cnt;

    logic         pace_load;
    logic         pace_en;
    logic         pace_expire;

    // Outcome of the latched action, consumed on the single ADVANCE cycle.
    always_comb begin
        adv_turn = seat_step(turn, dir, 2'd1);
        adv_dir  = dir;
        adv_pen  = 1'b0;
        adv_tgt  = pen_tgt;
        adv_cnt  = pen_cnt;
        case (act_q)
            ACT_SKIP: begin
                adv_turn = seat_step(turn, dir, 2'd2);
            end
            ACT_REVERSE: begin
                adv_dir  = ~dir;
                adv_turn = seat_step(turn, ~dir, 2'd1);
            end
            ACT_DRAW2, ACT_WILD4: begin
                adv_pen  = 1'b1;
                adv_tgt  = seat_step(turn, dir, 2'd1);
                adv_cnt  = (act_q == ACT_DRAW2) ? 3'd2 : 3'd4;
                adv_turn = seat_step(turn, dir, 2'd2);
            end
            default: begin
            end
        endcase
    end

    // Arm the pacing timer on the same edge that moves the FSM into PACE.
    always_comb begin
        pace_load = 1'b0;
        if (state == ST_ADVANCE && !adv_pen && adv_turn != HUMAN_SEAT)
            pace_load = 1'b1;
        else if (state == ST_PENALTY && i_penalty_ack && turn != HUMAN_SEAT)
            pace_load = 1'b1;
    end

    assign pace_en = (state == ST_PACE);

    uno_pace_timer #(
        .CW       (CW),
        .LOAD_VAL (PACE_LOAD)
    ) u_pace_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (pace_load),
        .i_en     (pace_en),
        .o_expire (pace_expire)
    );

    // Main turn FSM with all outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            turn    <= HUMAN_SEAT;
            dir     <= 1'b0;
            act_q   <= ACT_NORMAL;
            grant   <= 4'b0000;
            go      <= 1'b0;
            pen_req <= 1'b0;
            pen_tgt <= 2'd0;
            pen_cnt <= 3'd0;
            end_q   <= 1'b0;
            winner  <= 2'd0;
        end else begin
            go <= 1'b0;
            case (state)
                ST_IDLE, ST_END: begin
                    if (i_start) begin
                        turn  <= HUMAN_SEAT;
                        dir   <= 1'b0;
                        end_q <= 1'b0;
                        grant <= seat_onehot(HUMAN_SEAT);
                        go    <= 1'b1;
                        state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (i_done) begin
                        grant <= 4'b0000;
                        if (i_hand_empty) begin
                            winner <= turn;
                            end_q  <= 1'b1;
                            state  <= ST_END;
                        end else begin
                            act_q <= (i_action > 3'd5) ? ACT_NORMAL : action_e'(i_action);
                            state <= ST_ADVANCE;
                        end
                    end
                end
                ST_ADVANCE: begin
                    turn <= adv_turn;
                    dir  <= adv_dir;
                    if (adv_pen) begin
                        pen_req <= 1'b1;
                        pen_tgt <= adv_tgt;
                        pen_cnt <= adv_cnt;
                        state   <= ST_PENALTY;
                    end else if (adv_turn == HUMAN_SEAT) begin
                        grant <= seat_onehot(adv_turn);
                        go    <= 1'b1;
                        state <= ST_ACTIVE;
                    end else begin
                        state <= ST_PACE;
                    end
                end
                ST_PENALTY: begin
                    if (i_penalty_ack) begin
                        pen_req <= 1'b0;
                        if (turn == HUMAN_SEAT) begin
                            grant <= seat_onehot(turn);
                            go    <= 1'b1;
                            state <= ST_ACTIVE;
                        end else begin
                            state <= ST_PACE;
                        end
                    end
                end
                ST_PACE: begin
                    if (pace_expire) begin
                        grant <= seat_onehot(turn);
                        go    <= 1'b1;
                        state <= ST_ACTIVE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_turn           = turn;
    assign o_grant          = grant;
    assign o_go             = go;
    assign o_dir            = dir;
    assign o_penalty_req    = pen_req;
    assign o_penalty_target = pen_tgt;
    assign o_penalty_cnt    = pen_cnt;
    assign o_end            = end_q;
    assign o_winner         = winner;

endmodule

// File: tb/tb_uno_turn_scheduler.sv
// Bench for uno_turn_scheduler: directed action table, random game against a seat-arithmetic model.
// Latency: checks turn update, penalty handshake and o_go timing for human and computer seats.
// Backpressure: holds penalty requests unacknowledged and injects stray pulses that must be ignored.
module tb_uno_turn_scheduler;

    localparam int CD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       i_start = 1'b0;
    logic       i_done = 1'b0;
    logic [2:0] i_action = 3'd0;
    logic       i_hand_empty = 1'b0;
    logic       i_penalty_ack = 1'b0;
    logic [1:0] o_turn;
    logic [3:0] o_grant;
    logic       o_go;
    logic       o_dir;
    logic       o_penalty_req;
    logic [1:0] o_penalty_target;
    logic [2:0] o_penalty_cnt;
    logic       o_end;
    logic [1:0] o_winner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uno_turn_scheduler #(.COM_DELAY(CD), .CW(20)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (i_start),
        .i_done           (i_done),
        .i_action         (i_action),
        .i_hand_empty     (i_hand_empty),
        .i_penalty_ack    (i_penalty_ack),
        .o_turn           (o_turn),
        .o_grant          (o_grant),
        .o_go             (o_go),
        .o_dir            (o_dir),
        .o_penalty_req    (o_penalty_req),
        .o_penalty_target (o_penalty_target),
        .o_penalty_cnt    (o_penalty_cnt),
        .o_end            (o_end),
        .o_winner         (o_winner)
    );

    typedef struct {
        logic [2:0] act;
        logic       emp;
        int         hold;
        logic [1:0] turn;
        logic       dir;
        logic       pen;
        logic [1:0] tgt;
        logic [2:0] cnt;
        logic       over;
        logic [1:0] win;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] onehot(input logic [1:0] s);
        logic [3:0] one;
        one = 4'b0001;
        return one << s;
    endfunction

    // Reference: seat arithmetic straight from the game rules, on plain integers.
    task automatic model(input int act, inout int t, inout int d,
                         output int pen, output int tgt, output int cnt);
        int s;
        pen = 0; tgt = 0; cnt = 0;
        s = (d != 0) ? -1 : 1;
        case (act)
            1: t = (t + 2 * s + 8) % 4;
            2: begin d = 1 - d; s = -s; t = (t + s + 4) % 4; end
            3, 4: begin
                pen = 1;
                tgt = (t + s + 4) % 4;
                cnt = (act == 3) ? 2 : 4;
                t   = (t + 2 * s + 8) % 4;
            end
            default: t = (t + s + 4) % 4;
        endcase
    endtask

    // Wait for o_go, poking stray done/ack pulses into the pacing window.
    task automatic wait_go(input int exp_n, input string tag);
        int n;
        n = 0;
        while (o_go !== 1'b1 && n < 40) begin
            if (n == 0) chk({tag, "_pace_grant"}, o_grant, 4'b0000);
            if (n == 1) begin
                i_done = 1'b1; i_action = 3'd1; i_hand_empty = 1'b1; i_penalty_ack = 1'b1;
            end
            tick();
            i_done = 1'b0; i_hand_empty = 1'b0; i_penalty_ack = 1'b0;
            n++;
        end
        chk({tag, "_go_latency"}, n, exp_n);
    endtask

    task automatic do_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("start_end", o_end, 1'b0);
        chk("start_turn", o_turn, 2'd0);
        chk("start_dir", o_dir, 1'b0);
        chk("start_go", o_go, 1'b1);
        chk("start_grant", o_grant, 4'b0001);
    endtask

    // One granted turn; entered and left sampled on an o_go cycle.
    task automatic do_turn(input logic [2:0] act, input logic emp, input int pre, input int hold,
                           input logic [1:0] e_turn, input logic e_dir, input logic e_pen,
                           input logic [1:0] e_tgt, input logic [2:0] e_cnt,
                           input logic e_end, input logic [1:0] e_win);
        logic [1:0] t0;
        t0 = o_turn;
        if (pre > 0) begin
            i_start = 1'b1;
            tick();
            i_start = 1'b0;
            chk("go_one_cycle", o_go, 1'b0);
            chk("start_in_active", o_turn, t0);
            chk("grant_held", o_grant, onehot(t0));
            for (int k = 1; k < pre; k++) tick();
        end
        i_done = 1'b1; i_action = act; i_hand_empty = emp;
        tick();
        i_done = 1'b0; i_hand_empty = 1'b0;
        if (e_end) begin
            chk("end_flag", o_end, 1'b1);
            chk("end_winner", o_winner, e_win);
            chk("end_grant", o_grant, 4'b0000);
            i_done = 1'b1; i_action = 3'd0;
            tick();
            i_done = 1'b0;
            chk("end_hold_flag", o_end, 1'b1);
            chk("end_hold_winner", o_winner, e_win);
            return;
        end
        tick();
        chk("turn", o_turn, e_turn);
        chk("dir", o_dir, e_dir);
        chk("pen_req", o_penalty_req, e_pen);
        if (e_pen) begin
            chk("pen_target", o_penalty_target, e_tgt);
            chk("pen_cnt", o_penalty_cnt, e_cnt);
            for (int k = 0; k < hold; k++) begin
                i_done = 1'b1; i_hand_empty = 1'b1;
                tick();
                i_done = 1'b0; i_hand_empty = 1'b0;
            end
            chk("pen_req_held", o_penalty_req, 1'b1);
            chk("pen_target_held", o_penalty_target, e_tgt);
            chk("pen_cnt_held", o_penalty_cnt, e_cnt);
            chk("pen_turn_held", o_turn, e_turn);
            i_penalty_ack = 1'b1;
            tick();
            i_penalty_ack = 1'b0;
            chk("pen_req_drop", o_penalty_req, 1'b0);
        end
        wait_go((e_turn == 2'd0) ? 0 : CD, "turn");
        chk("go_turn", o_turn, e_turn);
        chk("go_grant", o_grant, onehot(e_turn));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int m_turn, m_dir, pen, tgt, cnt, act;
        logic emp;

        //        act   emp  hold turn  dir   pen   tgt   cnt   over  win
        tbl[0]  = '{3'd0, 1'b0, 0,  2'd1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0};
        tbl[1]  = '{3'd0, 1'b0, 0,  2'd2, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0};
        tbl[2]  = '{3'd0, 1'b0, 0,  2'd3, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0};
        tbl[3]  = '{3'd1, 1'b0, 0,  2'd1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0};
        tbl[4]  = '{3'd1, 1'b0, 0,  2'd3, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0};
        tbl[5]  = '{3'd7, 1'b0, 0,  2'd0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0};
        tbl[6]  = '{3'd2, 1'b0, 0,  2'd3, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0};
        tbl[7]  = '{3'd5, 1'b0, 0,  2'd2, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0};
        tbl[8]  = '{3'd3, 1'b0, 3,  2'd0, 1'b1, 1'b1, 2'd1, 3'd2, 1'b0, 2'd0};
        tbl[9]  = '{3'd2, 1'b0, 0,  2'd1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0};
        tbl[10] = '{3'd4, 1'b0, 10, 2'd3, 1'b0, 1'b1, 2'd2, 3'd4, 1'b0, 2'd0};
        tbl[11] = '{3'd1, 1'b0, 0,  2'd1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0};
        tbl[12] = '{3'd0, 1'b0, 0,  2'd2, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0};
        tbl[13] = '{3'd1, 1'b1, 0,  2'd2, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 2'd2};

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        chk("rst_turn", o_turn, 2'd0);
        chk("rst_grant", o_grant, 4'b0000);
        chk("rst_go", o_go, 1'b0);
        chk("rst_dir", o_dir, 1'b0);
        chk("rst_req", o_penalty_req, 1'b0);
        chk("rst_tgt", o_penalty_target, 2'd0);
        chk("rst_cnt", o_penalty_cnt, 3'd0);
        chk("rst_end", o_end, 1'b0);
        chk("rst_winner", o_winner, 2'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // i_done in IDLE is ignored
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        chk("idle_done_grant", o_grant, 4'b0000);
        chk("idle_done_go", o_go, 1'b0);

        // Directed table: one continuous game
        do_start();
        for (int i = 0; i < 14; i++) begin
            do_turn(tbl[i].act, tbl[i].emp, (i % 3 == 0) ? 1 : 0, tbl[i].hold,
                    tbl[i].turn, tbl[i].dir, tbl[i].pen, tbl[i].tgt, tbl[i].cnt,
                    tbl[i].over, tbl[i].win);
        end

        // Restart from END
        do_start();

        // Random game against the reference model
        m_turn = 0;
        m_dir = 0;
        for (int i = 0; i < 50; i++) begin
            act = $urandom_range(0, 7);
            emp = ($urandom_range(0, 11) == 0);
            if (emp) begin
                do_turn(3'(act), 1'b1, $urandom_range(0, 2), 0,
                        2'd0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 2'(m_turn));
                do_start();
                m_turn = 0;
                m_dir = 0;
            end else begin
                model(act, m_turn, m_dir, pen, tgt, cnt);
                do_turn(3'(act), 1'b0, $urandom_range(0, 2), $urandom_range(0, 4),
                        2'(m_turn), 1'(m_dir), 1'(pen), 2'(tgt), 3'(cnt), 1'b0, 2'd0);
            end
        end

        // Reset while a penalty request is pending
        i_done = 1'b1; i_action = 3'd4; i_hand_empty = 1'b0;
        tick();
        i_done = 1'b0;
        tick();
        chk("mid_pen_req", o_penalty_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req", o_penalty_req, 1'b0);
        chk("async_rst_cnt", o_penalty_cnt, 3'd0);
        chk("async_rst_tgt", o_penalty_target, 2'd0);
        chk("async_rst_turn", o_turn, 2'd0);
        chk("async_rst_dir", o_dir, 1'b0);
        chk("async_rst_grant", o_grant, 4'b0000);
        tick();
        tick();
        #2 rst_n = 1'b1;
        i_penalty_ack = 1'b1;
        tick();
        i_penalty_ack = 1'b0;
        tick();
        chk("post_rst_req", o_penalty_req, 1'b0);
        chk("post_rst_go", o_go, 1'b0);
        do_start();
        do_turn(3'd0, 1'b0, 0, 0, 2'd1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
